instr_loader: RTL

- Boot-time writer for the instruction memory, the counterpart of the core's read-only instruction fetch port.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver. The stream carries a 32-bit little-endian word count followed by that many 32-bit little-endian instruction words.
- Writes each word to sequential word addresses starting at 0 through a single write port.
- Holds the core in reset until the image is fully loaded.

---
 rtl/instr_loader_if.sv | 20 ++
 rtl/instr_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave view belongs to the loader; the master view to its environment.
interface instr_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Boot-time instruction memory writer: parses a little-endian word count and
// that many words from a byte stream, and holds the core in reset until done.
module instr_loader #(
    parameter int DEPTH = 100
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    instr_loader_if.slave  bus,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic           core_rst_n
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, LAST, DONE, ERR} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state;
    state_t      next_state;
    logic [1:0]  byte_cnt;
    logic [31:0] word_cnt;
    logic [31:0] length;
    logic [23:0] shift;
    logic        accept;
    logic        word_end;
    logic        can_start;
    logic [31:0] full_word;
    logic        ready_d;
    logic        busy_d;
    logic        done_d;
    logic        error_d;
    logic        core_rst_d;

    assign accept    = bus.in_valid && bus.in_ready;
    assign word_end  = accept && (byte_cnt == 2'd3);
    assign can_start = start && (state inside {IDLE, DONE, ERR});
    assign full_word = {bus.in_data, shift};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            core_rst_n   <= 1'b0;
        end else begin
            state        <= next_state;
            bus.in_ready <= ready_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            core_rst_n   <= core_rst_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) next_state = LEN;
            end
            LEN: begin
                if (word_end) begin
                    if (full_word == 32'd0)       next_state = DONE;
                    else if (full_word > DEPTH_W) next_state = ERR;
                    else                          next_state = DATA;
                end
            end
            DATA: begin
                if (word_end && (word_cnt == length - 32'd1)) next_state = LAST;
            end
            LAST:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they land in flops
    // together with the state itself.
    always_comb begin
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        core_rst_d = 1'b0;
        case (next_state)
            LEN, DATA: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            LAST: busy_d = 1'b1;
            DONE: begin
                done_d     = 1'b1;
                core_rst_d = 1'b1;
            end
            ERR:     error_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= 2'd0;
            word_cnt  <= 32'd0;
            length    <= 32'd0;
            shift     <= 24'd0;
            bus.we    <= 1'b0;
            bus.waddr <= 32'd0;
            bus.wdata <= 32'd0;
        end else begin
            bus.we <= 1'b0;
            if (can_start) begin
                byte_cnt  <= 2'd0;
                word_cnt  <= 32'd0;
                bus.waddr <= 32'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: shift[7:0]   <= bus.in_data;
                    2'd1: shift[15:8]  <= bus.in_data;
                    2'd2: shift[23:16] <= bus.in_data;
                    default: begin
                        // Accepts only happen in LEN or DATA.
                        if (state == LEN) begin
                            length <= full_word;
                        end else begin
                            bus.we    <= 1'b1;
                            bus.waddr <= word_cnt;
                            bus.wdata <= full_word;
                            word_cnt  <= word_cnt + 32'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
